// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM round-robin arbiter slice.
//   NREQ            number of requester ports sharing the BRAM
//   lock_state_e    lock tracker states (IDLE / LOCKED)
//   lock_cnt_width  width of a counter able to hold 0..max_lock
package bram_arb_pkg;

   localparam int NREQ = 2;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   function automatic int lock_cnt_width(input int max_lock);
      return $clog2(max_lock + 1);
   endfunction

endpackage

// File: rtl/bram_rsp_slot.sv
// Per-port read response slot.
// Presents BRAM read data to one requester with valid/ready backpressure.
// The BRAM output is only trusted in the cycle right after the read, so
// on the first stalled cycle the word is copied into a hold register and
// served from there until the requester takes it.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   issue_rd      a read for this port is being issued to the BRAM this cycle
//   bram_rddata   BRAM read data (valid the cycle after issue_rd)
//   rsp_ready     requester consumes the response
//   rsp_valid     response valid
//   rsp_rddata    response data
module bram_rsp_slot
   import bram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_rd,
   input  logic [DATA_WIDTH-1:0] bram_rddata,
   input  logic                  rsp_ready,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rddata
);

   logic                  valid_r;
   logic                  held_r;
   logic [DATA_WIDTH-1:0] hold_r;

   // Response valid flag plus capture of the word on the first stall cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         held_r  <= 1'b0;
         hold_r  <= {DATA_WIDTH{1'b0}};
      end else if (issue_rd) begin
         // a new read replaces (or follows a consumed) response
         valid_r <= 1'b1;
         held_r  <= 1'b0;
      end else if (valid_r && rsp_ready) begin
         valid_r <= 1'b0;
         held_r  <= 1'b0;
      end else if (valid_r && !held_r) begin
         // first stalled cycle: BRAM output still holds our word
         held_r  <= 1'b1;
         hold_r  <= bram_rddata;
      end else begin
         valid_r <= valid_r;
         held_r  <= held_r;
      end
   end

   assign rsp_valid  = valid_r;
   assign rsp_rddata = held_r ? hold_r : bram_rddata;

endmodule

// File: rtl/bram_rr_arbiter.sv
// Shares one single-port BRAM (1-cycle read latency) between two requesters.
// Round-robin per access; a requester may lock the grant for up to MAX_LOCK
// consecutive accesses. Reads return through a per-port response slot.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake per port (ready is combinational)
//   req_lock                      keep the grant after this beat
//   req_we/req_addr/req_wrdata    byte strobes (all zero = read), address, write data
//   rsp_valid/rsp_ready/rsp_rddata read response per port
//   bram_*                        shared BRAM macro interface
module bram_rr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int BRAM_ADDR_WIDTH = 16,
   parameter int MAX_LOCK        = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NREQ-1:0]                      req_valid,
   output logic [NREQ-1:0]                      req_ready,
   input  logic [NREQ-1:0]                      req_lock,
   input  logic [NREQ-1:0][DATA_WIDTH/8-1:0]    req_we,
   input  logic [NREQ-1:0][BRAM_ADDR_WIDTH-1:0] req_addr,
   input  logic [NREQ-1:0][DATA_WIDTH-1:0]      req_wrdata,
   output logic [NREQ-1:0]                      rsp_valid,
   input  logic [NREQ-1:0]                      rsp_ready,
   output logic [NREQ-1:0][DATA_WIDTH-1:0]      rsp_rddata,
   output logic                                 bram_clk,
   output logic                                 bram_rst,
   output logic                                 bram_en,
   output logic [DATA_WIDTH/8-1:0]              bram_we,
   output logic [BRAM_ADDR_WIDTH-1:0]           bram_addr,
   output logic [DATA_WIDTH-1:0]                bram_wrdata,
   input  logic [DATA_WIDTH-1:0]                bram_rddata
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = lock_cnt_width(MAX_LOCK);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

   lock_state_e     state_r, state_s;
   logic            owner_r, owner_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic            prio_r, prio_s;
   logic [NREQ-1:0] elig_s;
   logic            gnt_vld_s;
   logic            gnt_idx_s;
   logic            cont_s;
   logic [CW-1:0]   run_s;
   logic [NREQ-1:0] issue_rd_s;

   assign bram_clk = clk;
   assign bram_rst = rst;

   // A port may only be granted if its response slot can take a new beat
   assign elig_s = req_valid & (~rsp_valid | rsp_ready);

   // Grant selection: eligible lock owner first, then round-robin from prio
   always_comb begin
      gnt_vld_s = 1'b0;
      gnt_idx_s = 1'b0;
      if (rst) begin
         gnt_vld_s = 1'b0;
      end else if ((state_r == LOCKED) && elig_s[owner_r]) begin
         gnt_vld_s = 1'b1;
         gnt_idx_s = owner_r;
      end else if (elig_s[prio_r]) begin
         gnt_vld_s = 1'b1;
         gnt_idx_s = prio_r;
      end else if (elig_s[~prio_r]) begin
         gnt_vld_s = 1'b1;
         gnt_idx_s = ~prio_r;
      end else begin
         gnt_vld_s = 1'b0;
      end
   end

   // Lock tracker next state, run length and next priority
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      cnt_s   = cnt_r;
      prio_s  = prio_r;
      cont_s  = 1'b0;
      case (state_r)
         LOCKED:  cont_s = (owner_r == gnt_idx_s);
         IDLE:    cont_s = 1'b0;
         default: cont_s = 1'b0;
      endcase
      // a continuing owner extends its run; anyone else starts at one
      run_s = cont_s ? (cnt_r + CNT_ONE) : CNT_ONE;
      if (gnt_vld_s) begin
         prio_s = ~gnt_idx_s;
         if (req_lock[gnt_idx_s] && (run_s != CNT_MAX)) begin
            state_s = LOCKED;
            owner_s = gnt_idx_s;
            cnt_s   = run_s;
         end else begin
            // lock dropped or run exhausted; prio already points at the other port
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
         end
      end else begin
         // no grant means any owner was not eligible: release
         state_s = IDLE;
         cnt_s   = {CW{1'b0}};
      end
   end

   // Arbiter state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         owner_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         prio_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         cnt_r   <= cnt_s;
         prio_r  <= prio_s;
      end
   end

   // Route the granted request to the BRAM and flag reads for the slot
   always_comb begin
      req_ready   = {NREQ{1'b0}};
      issue_rd_s  = {NREQ{1'b0}};
      bram_en     = 1'b0;
      bram_we     = {SW{1'b0}};
      bram_addr   = {BRAM_ADDR_WIDTH{1'b0}};
      bram_wrdata = {DATA_WIDTH{1'b0}};
      if (gnt_vld_s) begin
         req_ready[gnt_idx_s]  = 1'b1;
         bram_en               = 1'b1;
         bram_we               = req_we[gnt_idx_s];
         bram_addr             = req_addr[gnt_idx_s];
         bram_wrdata           = req_wrdata[gnt_idx_s];
         issue_rd_s[gnt_idx_s] = (req_we[gnt_idx_s] == {SW{1'b0}});
      end else begin
         bram_en = 1'b0;
      end
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_slot
      bram_rsp_slot #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
         .clk         (clk),
         .rst         (rst),
         .issue_rd    (issue_rd_s[i]),
         .bram_rddata (bram_rddata),
         .rsp_ready   (rsp_ready[i]),
         .rsp_valid   (rsp_valid[i]),
         .rsp_rddata  (rsp_rddata[i])
      );
   end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Self-checking bench for bram_rr_arbiter: directed scenarios followed by a
// randomized run, all checked against a cycle-level behavioural model of the
// arbitration, lock and response rules plus a shadow copy of memory.
module tb_bram_rr_arbiter;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int SW = DW / 8;
   localparam int ML = 4;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]          req_valid, req_ready, req_lock, rsp_valid, rsp_ready;
   logic [1:0][SW-1:0]  req_we;
   logic [1:0][AW-1:0]  req_addr;
   logic [1:0][DW-1:0]  req_wrdata, rsp_rddata;
   logic                bram_clk, bram_rst, bram_en;
   logic [SW-1:0]       bram_we;
   logic [AW-1:0]       bram_addr;
   logic [DW-1:0]       bram_wrdata, bram_rddata;

   int tests = 0;
   int fails = 0;

   // model state
   logic [DW-1:0] shadow [256];
   int            prio_m  = 0;
   int            owner_m = -1;
   int            cnt_m   = 0;
   bit            exp_v [2];
   logic [DW-1:0] exp_d [2];
   logic [1:0]    obs_rdy;

   // BRAM macro model storage
   logic [DW-1:0] bram_mem [256];
   bit            bram_written [256];

   always #5 clk = ~clk;

   bram_rr_arbiter #(
      .DATA_WIDTH (DW), .BRAM_ADDR_WIDTH (AW), .MAX_LOCK (ML)
   ) dut (
      .clk (clk), .rst (rst),
      .req_valid (req_valid), .req_ready (req_ready), .req_lock (req_lock),
      .req_we (req_we), .req_addr (req_addr), .req_wrdata (req_wrdata),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rddata (rsp_rddata),
      .bram_clk (bram_clk), .bram_rst (bram_rst), .bram_en (bram_en),
      .bram_we (bram_we), .bram_addr (bram_addr), .bram_wrdata (bram_wrdata),
      .bram_rddata (bram_rddata)
   );

   function automatic logic [DW-1:0] init_word(input logic [7:0] a);
      if (a == 8'h10)      return 32'hDEADBEEF;
      else if (a == 8'h20) return 32'hAABBCCDD;
      else                 return {a, ~a, a ^ 8'h5A, 8'hC3};
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                           input logic [DW-1:0] new_w,
                                           input logic [SW-1:0] we);
      logic [DW-1:0] r;
      r = old_w;
      for (int b = 0; b < SW; b++)
         if (we[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   function automatic logic [DW-1:0] bram_word(input logic [7:0] a);
      return bram_written[a] ? bram_mem[a] : init_word(a);
   endfunction

   // BRAM: read-first, 1-cycle latency; output is garbage when not reading
   always @(posedge clk) begin
      if (bram_en && (bram_we == 4'b0000))
         bram_rddata <= bram_word(bram_addr[7:0]);
      else
         bram_rddata <= $urandom;
      if (bram_en && (bram_we != 4'b0000)) begin
         bram_mem[bram_addr[7:0]]     <= merge(bram_word(bram_addr[7:0]), bram_wrdata, bram_we);
         bram_written[bram_addr[7:0]] <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs against the model, then advance the model.
   task automatic step();
      int g;
      bit el [2];
      logic [1:0] exp_rdy;
      #2;
      for (int i = 0; i < 2; i++)
         el[i] = req_valid[i] && (!exp_v[i] || rsp_ready[i]);
      g = -1;
      if (rst)                              g = -1;
      else if (owner_m >= 0 && el[owner_m]) g = owner_m;
      else if (el[prio_m])                  g = prio_m;
      else if (el[1-prio_m])                g = 1 - prio_m;
      exp_rdy = (g < 0) ? 2'b00 : (2'b01 << g);
      obs_rdy = req_ready;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("bram_en", 64'(bram_en), 64'(g >= 0));
      if (g >= 0) begin
         check("bram_addr", 64'(bram_addr), 64'(req_addr[g]));
         check("bram_we", 64'(bram_we), 64'(req_we[g]));
         if (req_we[g] != 4'b0000)
            check("bram_wrdata", 64'(bram_wrdata), 64'(req_wrdata[g]));
      end
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rsp_valid%0d", i), 64'(rsp_valid[i]), 64'(exp_v[i]));
         if (exp_v[i])
            check($sformatf("rsp_rddata%0d", i), 64'(rsp_rddata[i]), 64'(exp_d[i]));
      end
      @(posedge clk);
      if (rst) begin
         exp_v[0] = 1'b0; exp_v[1] = 1'b0;
         prio_m = 0; owner_m = -1; cnt_m = 0;
      end else begin
         for (int i = 0; i < 2; i++)
            if (exp_v[i] && rsp_ready[i]) exp_v[i] = 1'b0;
         if (owner_m >= 0 && !el[owner_m]) begin
            owner_m = -1; cnt_m = 0;
         end
         if (g >= 0) begin
            prio_m = 1 - g;
            if (req_we[g] == 4'b0000) begin
               exp_v[g] = 1'b1;
               exp_d[g] = shadow[req_addr[g][7:0]];
            end else begin
               shadow[req_addr[g][7:0]] = merge(shadow[req_addr[g][7:0]], req_wrdata[g], req_we[g]);
            end
            if (req_lock[g]) begin
               if (owner_m != g) cnt_m = 0;
               cnt_m++;
               if (cnt_m >= ML) begin owner_m = -1; cnt_m = 0; end
               else owner_m = g;
            end else begin
               owner_m = -1; cnt_m = 0;
            end
         end
      end
      #1;
   endtask

   logic [1:0] lock_exp [6];

   initial begin
      for (int a = 0; a < 256; a++) shadow[a] = init_word(8'(a));
      exp_v[0] = 1'b0; exp_v[1] = 1'b0;
      rst = 1'b1; req_valid = 2'b00; req_lock = 2'b00; rsp_ready = 2'b11;
      req_we = '0; req_addr = '0; req_wrdata = '0;
      @(posedge clk); @(posedge clk); #1;

      // reset state
      check("bram_rst", 64'(bram_rst), 64'(1'b1));
      check("bram_clk", 64'(bram_clk), 64'(clk));
      step();
      rst = 1'b0;
      step();

      // single read of port 0
      req_valid = 2'b01; req_addr[0] = 16'h0010;
      step();
      req_valid = 2'b00;
      check("p0_read_valid", 64'(rsp_valid[0]), 64'(1'b1));
      check("p0_read_data", 64'(rsp_rddata[0]), 64'(32'hDEADBEEF));
      step(); step();

      // both ports reading every cycle, no lock
      for (int k = 0; k < 8; k++) begin
         req_valid = 2'b11;
         req_addr[0] = 16'($urandom_range(0, 255));
         req_addr[1] = 16'($urandom_range(0, 255));
         step();
      end
      req_valid = 2'b00; step(); step();

      // partial write, then read back
      req_valid = 2'b01; req_we[0] = 4'b0011; req_addr[0] = 16'h0020; req_wrdata[0] = 32'h12345678;
      step();
      check("no_rsp_for_write", 64'(rsp_valid[0]), 64'(1'b0));
      req_we[0] = 4'b0000;
      step();
      req_valid = 2'b00;
      check("rmw_data", 64'(rsp_rddata[0]), 64'(32'hAABB5678));
      step(); step();

      // port 1 response stalled while port 0 streams
      req_valid = 2'b10; req_addr[1] = 16'h0030; rsp_ready = 2'b01;
      step();
      for (int k = 0; k < 5; k++) begin
         req_valid = 2'b11; req_addr[1] = 16'h0031;
         req_addr[0] = 16'($urandom_range(0, 255));
         step();
         check("p1_held_data", 64'(rsp_rddata[1]), 64'(init_word(8'h30)));
      end
      rsp_ready = 2'b11;
      step();
      req_valid = 2'b00; step(); step();

      // lock burst bounded by MAX_LOCK
      rst = 1'b1; step(); rst = 1'b0;
      lock_exp[0] = 2'b01; lock_exp[1] = 2'b01; lock_exp[2] = 2'b01;
      lock_exp[3] = 2'b01; lock_exp[4] = 2'b10; lock_exp[5] = 2'b01;
      req_valid = 2'b11; req_lock = 2'b01;
      for (int k = 0; k < 6; k++) begin
         req_addr[0] = 16'($urandom_range(0, 255));
         req_addr[1] = 16'($urandom_range(0, 255));
         step();
         check($sformatf("lock_seq%0d", k), 64'(obs_rdy), 64'(lock_exp[k]));
      end
      req_valid = 2'b00; req_lock = 2'b00; step(); step();

      // reset while port 1 response is stalled
      req_valid = 2'b10; req_addr[1] = 16'h0040; rsp_ready = 2'b01;
      step();
      req_valid = 2'b00;
      step(); step();
      rst = 1'b1; step(); rst = 1'b0;
      check("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
      req_valid = 2'b11; rsp_ready = 2'b11;
      step();
      check("rst_prio0", 64'(obs_rdy), 64'(2'b01));
      req_valid = 2'b00; step(); step();

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 2; i++) begin
            req_valid[i]  = ($urandom_range(0, 3) != 0);
            req_lock[i]   = ($urandom_range(0, 2) == 0);
            req_we[i]     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            req_addr[i]   = 16'($urandom_range(0, 31));
            req_wrdata[i] = $urandom;
            rsp_ready[i]  = ($urandom_range(0, 3) != 0);
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
